ita_hwpe_stream_engine: RTL and testbench

ITA_HWPE_STREAM_ENGINE -- requirements
Module: ita_hwpe_stream_engine

---
 rtl/ita_hwpe_package.sv | 21 ++
 rtl/ita_hwpe_fifo.sv | 75 +++++++
 rtl/ita_hwpe_stream_engine.sv | 160 ++++++++++++++++
 tb/tb_ita_hwpe_stream_engine.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ita_hwpe_package.sv
// rtl/ita_hwpe_package.sv - shared types and default constants for the ITA HWPE stream engine
//
// Purpose: holds the engine FSM state encoding and the default stream widths,
//          FIFO depth and beat-counter width used by the engine top level.
// Ports:   none (package).
package ita_hwpe_package;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int unsigned DEF_INP_DW     = 128;
  localparam int unsigned DEF_WGT_DW     = 128;
  localparam int unsigned DEF_BIAS_DW    = 384;
  localparam int unsigned DEF_OUT_DW     = 128;
  localparam int unsigned DEF_FIFO_DEPTH = 4;
  localparam int unsigned DEF_CNT_W      = 16;

endpackage

// File: rtl/ita_hwpe_fifo.sv
// rtl/ita_hwpe_fifo.sv - first-word-fall-through stream FIFO with soft clear
//
// Purpose: DEPTH-entry ring buffer; head entry is presented combinationally,
//          so data pushed on one edge is visible the following cycle.
// Ports:   i_clk, i_rst_n (async, active-low), i_clear (sync flush);
//          i_valid/o_ready/i_data  - write side, o_ready = not full;
//          o_valid/i_ready/o_data  - read side, o_valid = not empty.
module ita_hwpe_fifo #(
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_clear,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic [DW-1:0] i_data,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [DW-1:0] o_data
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_cnt;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  assign w_full  = (r_cnt == FULL_CNT);
  assign w_empty = (r_cnt == '0);

  // Ready is held low while in reset and during a flush so no upstream
  // beat is ever reported as accepted and then silently dropped.
  assign o_ready = i_rst_n & ~i_clear & ~w_full;
  assign o_valid = ~i_clear & ~w_empty;
  assign o_data  = r_mem[r_rd_ptr];

  // Push depends only on not-full, so a pop in the same cycle never frees a slot early.
  assign w_push = i_valid & o_ready;
  assign w_pop  = o_valid & i_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Payload storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/ita_hwpe_stream_engine.sv
// rtl/ita_hwpe_stream_engine.sv - stream engine buffering core operands and framing output jobs
//
// Purpose: buffers the input, weight and bias streams toward the core and the
//          core result stream toward the output, each through its own FIFO.
//          A job of out_beats_i output beats is framed by an IDLE/RUN/DONE FSM
//          that counts delivered beats, applies the tail strobe on the last one
//          and pulses done_o once.
// Ports:   clk_i, rst_ni (async, active-low), clear_i (sync soft clear);
//          start_i, out_beats_i, tail_strb_i - job control;
//          inp_*/wgt_*/bias_* - operand streams in; core_inp_*/core_wgt_*/core_bias_* - to core;
//          core_oup_* - results from core; core_busy_i - core activity flag;
//          oup_valid_o/oup_ready_i/oup_data_o/oup_strb_o - framed output stream;
//          busy_o, done_o, beat_cnt_o - job status.
module ita_hwpe_stream_engine
  import ita_hwpe_package::*;
#(
  parameter int unsigned INP_DW     = DEF_INP_DW,
  parameter int unsigned WGT_DW     = DEF_WGT_DW,
  parameter int unsigned BIAS_DW    = DEF_BIAS_DW,
  parameter int unsigned OUT_DW     = DEF_OUT_DW,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int unsigned CNT_W      = DEF_CNT_W
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  start_i,
  input  logic [CNT_W-1:0]      out_beats_i,
  input  logic [OUT_DW/8-1:0]   tail_strb_i,
  input  logic                  inp_valid_i,
  output logic                  inp_ready_o,
  input  logic [INP_DW-1:0]     inp_data_i,
  input  logic                  wgt_valid_i,
  output logic                  wgt_ready_o,
  input  logic [WGT_DW-1:0]     wgt_data_i,
  input  logic                  bias_valid_i,
  output logic                  bias_ready_o,
  input  logic [BIAS_DW-1:0]    bias_data_i,
  output logic                  core_inp_valid_o,
  input  logic                  core_inp_ready_i,
  output logic [INP_DW-1:0]     core_inp_data_o,
  output logic                  core_wgt_valid_o,
  input  logic                  core_wgt_ready_i,
  output logic [WGT_DW-1:0]     core_wgt_data_o,
  output logic                  core_bias_valid_o,
  input  logic                  core_bias_ready_i,
  output logic [BIAS_DW-1:0]    core_bias_data_o,
  input  logic                  core_oup_valid_i,
  output logic                  core_oup_ready_o,
  input  logic [OUT_DW-1:0]     core_oup_data_i,
  input  logic                  core_busy_i,
  output logic                  oup_valid_o,
  input  logic                  oup_ready_i,
  output logic [OUT_DW-1:0]     oup_data_o,
  output logic [OUT_DW/8-1:0]   oup_strb_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [CNT_W-1:0]      beat_cnt_o
);

  localparam int unsigned SW = OUT_DW / 8;

  state_e            r_state;
  state_e            w_next_state;
  logic [CNT_W-1:0]  r_beats;
  logic [SW-1:0]     r_tail;
  logic [CNT_W-1:0]  r_beat_cnt;

  logic              w_oup_fifo_valid;
  logic              w_oup_fifo_ready;
  logic              w_start_acc;
  logic              w_oup_hs;
  logic              w_last_beat;
  logic [SW-1:0]     w_tail_eff;

  // Operand FIFOs accept in every state so the next job can be prefetched.
  ita_hwpe_fifo #(.DW(INP_DW), .DEPTH(FIFO_DEPTH)) u_inp_fifo (
    .i_clk(clk_i), .i_rst_n(rst_ni), .i_clear(clear_i),
    .i_valid(inp_valid_i), .o_ready(inp_ready_o), .i_data(inp_data_i),
    .o_valid(core_inp_valid_o), .i_ready(core_inp_ready_i), .o_data(core_inp_data_o)
  );

  ita_hwpe_fifo #(.DW(WGT_DW), .DEPTH(FIFO_DEPTH)) u_wgt_fifo (
    .i_clk(clk_i), .i_rst_n(rst_ni), .i_clear(clear_i),
    .i_valid(wgt_valid_i), .o_ready(wgt_ready_o), .i_data(wgt_data_i),
    .o_valid(core_wgt_valid_o), .i_ready(core_wgt_ready_i), .o_data(core_wgt_data_o)
  );

  ita_hwpe_fifo #(.DW(BIAS_DW), .DEPTH(FIFO_DEPTH)) u_bias_fifo (
    .i_clk(clk_i), .i_rst_n(rst_ni), .i_clear(clear_i),
    .i_valid(bias_valid_i), .o_ready(bias_ready_o), .i_data(bias_data_i),
    .o_valid(core_bias_valid_o), .i_ready(core_bias_ready_i), .o_data(core_bias_data_o)
  );

  ita_hwpe_fifo #(.DW(OUT_DW), .DEPTH(FIFO_DEPTH)) u_oup_fifo (
    .i_clk(clk_i), .i_rst_n(rst_ni), .i_clear(clear_i),
    .i_valid(core_oup_valid_i), .o_ready(core_oup_ready_o), .i_data(core_oup_data_i),
    .o_valid(w_oup_fifo_valid), .i_ready(w_oup_fifo_ready), .o_data(oup_data_o)
  );

  assign w_start_acc = (r_state == ST_IDLE) & start_i & ~clear_i;
  assign w_oup_hs    = oup_valid_o & oup_ready_i;
  assign w_last_beat = (r_beat_cnt == r_beats - CNT_W'(1));
  // A zero tail strobe would mean an empty final beat; treat it as a full one.
  assign w_tail_eff  = (r_tail == '0) ? '1 : r_tail;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= ST_IDLE;
    else         r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (clear_i) begin
      w_next_state = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE: if (start_i) w_next_state = (out_beats_i == '0) ? ST_DONE : ST_RUN;
        ST_RUN:  if (w_oup_hs && w_last_beat) w_next_state = ST_DONE;
        ST_DONE: w_next_state = ST_IDLE;
        default: w_next_state = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    oup_valid_o      = 1'b0;
    w_oup_fifo_ready = 1'b0;
    done_o           = 1'b0;
    unique case (r_state)
      ST_RUN: begin
        oup_valid_o      = w_oup_fifo_valid;
        w_oup_fifo_ready = oup_ready_i;
      end
      ST_DONE: done_o = ~clear_i;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_beats    <= '0;
      r_tail     <= '0;
      r_beat_cnt <= '0;
    end else if (clear_i) begin
      r_beat_cnt <= '0;
    end else if (w_start_acc) begin
      r_beats    <= out_beats_i;
      r_tail     <= tail_strb_i;
      r_beat_cnt <= '0;
    end else if (w_oup_hs) begin
      r_beat_cnt <= r_beat_cnt + CNT_W'(1);
    end
  end

  assign oup_strb_o = ((r_state == ST_RUN) && w_last_beat) ? w_tail_eff : '1;
  assign busy_o     = (r_state != ST_IDLE) | core_busy_i;
  assign beat_cnt_o = r_beat_cnt;

endmodule

// File: tb/tb_ita_hwpe_stream_engine.sv
// tb/tb_ita_hwpe_stream_engine.sv - self-checking bench for ita_hwpe_stream_engine
module tb_ita_hwpe_stream_engine;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          clear_i;
  logic          start_i;
  logic [15:0]   out_beats_i;
  logic [15:0]   tail_strb_i;
  logic          inp_valid_i, inp_ready_o;
  logic [127:0]  inp_data_i;
  logic          wgt_valid_i, wgt_ready_o;
  logic [127:0]  wgt_data_i;
  logic          bias_valid_i, bias_ready_o;
  logic [383:0]  bias_data_i;
  logic          core_inp_valid_o, core_inp_ready_i;
  logic [127:0]  core_inp_data_o;
  logic          core_wgt_valid_o, core_wgt_ready_i;
  logic [127:0]  core_wgt_data_o;
  logic          core_bias_valid_o, core_bias_ready_i;
  logic [383:0]  core_bias_data_o;
  logic          core_oup_valid_i, core_oup_ready_o;
  logic [127:0]  core_oup_data_i;
  logic          core_busy_i;
  logic          oup_valid_o, oup_ready_i;
  logic [127:0]  oup_data_o;
  logic [15:0]   oup_strb_o;
  logic          busy_o, done_o;
  logic [15:0]   beat_cnt_o;

  always #5 clk_i = ~clk_i;

  ita_hwpe_stream_engine dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .start_i(start_i),
    .out_beats_i(out_beats_i), .tail_strb_i(tail_strb_i),
    .inp_valid_i(inp_valid_i), .inp_ready_o(inp_ready_o), .inp_data_i(inp_data_i),
    .wgt_valid_i(wgt_valid_i), .wgt_ready_o(wgt_ready_o), .wgt_data_i(wgt_data_i),
    .bias_valid_i(bias_valid_i), .bias_ready_o(bias_ready_o), .bias_data_i(bias_data_i),
    .core_inp_valid_o(core_inp_valid_o), .core_inp_ready_i(core_inp_ready_i), .core_inp_data_o(core_inp_data_o),
    .core_wgt_valid_o(core_wgt_valid_o), .core_wgt_ready_i(core_wgt_ready_i), .core_wgt_data_o(core_wgt_data_o),
    .core_bias_valid_o(core_bias_valid_o), .core_bias_ready_i(core_bias_ready_i), .core_bias_data_o(core_bias_data_o),
    .core_oup_valid_i(core_oup_valid_i), .core_oup_ready_o(core_oup_ready_o), .core_oup_data_i(core_oup_data_i),
    .core_busy_i(core_busy_i),
    .oup_valid_o(oup_valid_o), .oup_ready_i(oup_ready_i), .oup_data_o(oup_data_o), .oup_strb_o(oup_strb_o),
    .busy_o(busy_o), .done_o(done_o), .beat_cnt_o(beat_cnt_o)
  );

  typedef struct packed {
    logic [127:0] data;
    logic [15:0]  strb;
  } exp_t;

  typedef struct {
    int          beats;
    logic [15:0] tail;
    bit          rnd_ready;
    bit          restart;
    logic [15:0] exp_last_strb;
    logic [15:0] exp_cnt;
  } job_t;

  exp_t          exp_q[$];
  logic [127:0]  inp_q[$];
  logic [383:0]  bias_q[$];
  job_t          jobs[6];
  int            n_vec = 0;
  int            n_err = 0;

  task automatic chk(input string name, input logic [383:0] act, input logic [383:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Core model: offers n result beats and records each accepted one with its expected strobe.
  task automatic produce(input int n, input logic [15:0] last_strb);
    int   sent;
    int   guard;
    logic acc;
    exp_t e;
    sent  = 0;
    guard = 0;
    while (sent < n && guard < 2000) begin
      core_oup_valid_i = 1'b1;
      core_oup_data_i  = {$urandom, $urandom, $urandom, $urandom};
      acc = 1'b0;
      while (!acc && guard < 2000) begin
        @(negedge clk_i);
        acc = core_oup_ready_o;
        tick();
        guard++;
      end
      if (acc) begin
        e.data = core_oup_data_i;
        e.strb = (sent == n - 1) ? last_strb : 16'hFFFF;
        exp_q.push_back(e);
        sent++;
      end
    end
    core_oup_valid_i = 1'b0;
  endtask

  task automatic consume(input job_t j);
    int           got;
    int           cyc;
    bit           early;
    bit           prev_stall;
    bit           restarted;
    logic [127:0] prev_data;
    exp_t         e;
    start_i     = 1'b1;
    out_beats_i = 16'(j.beats);
    tail_strb_i = j.tail;
    tick();
    start_i = 1'b0;
    got = 0; cyc = 0; early = 0; prev_stall = 0; restarted = 0; prev_data = '0;
    while (got < j.beats && cyc < 500) begin
      oup_ready_i = j.rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (j.restart && got == 1 && !restarted) begin
        start_i     = 1'b1;
        out_beats_i = 16'd7;
        restarted   = 1;
      end
      @(negedge clk_i);
      if (done_o) early = 1;
      if (prev_stall) begin
        chk("stall_valid", oup_valid_o, 1'b1);
        chk("stall_data", oup_data_o, prev_data);
      end
      if (oup_valid_o && oup_ready_i) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          chk("oup_data", oup_data_o, e.data);
          chk("oup_strb", oup_strb_o, e.strb);
        end
        got++;
      end
      prev_stall = oup_valid_o && !oup_ready_i;
      prev_data  = oup_data_o;
      tick();
      start_i = 1'b0;
      cyc++;
    end
    if (cyc >= 500) chk("job_timeout_beats", 32'(got), 32'(j.beats));
    @(negedge clk_i);
    chk("early_done", early, 1'b0);
    chk("done_pulse", done_o, 1'b1);
    chk("beat_cnt_final", beat_cnt_o, j.exp_cnt);
    tick();
    @(negedge clk_i);
    chk("done_one_cycle", done_o, 1'b0);
    chk("idle_not_busy", busy_o, 1'b0);
    chk("no_extra_beat", oup_valid_o, 1'b0);
    chk("beat_cnt_hold", beat_cnt_o, j.exp_cnt);
    tick();
  endtask

  task automatic run_job(input job_t j);
    fork
      produce(j.beats, j.exp_last_strb);
      consume(j);
    join
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not reach the summary");
    $fatal(1);
  end

  initial begin
    logic acc;
    int   acc_n;
    int   drained;
    int   got;
    int   cyc;
    int   sent;
    int   recv;
    bit   stall_seen;
    bit   any_done;

    //            beats tail      rnd rst  last_strb  cnt
    jobs[0] = '{3, 16'h00FF, 0, 0, 16'h00FF, 16'd3};
    jobs[1] = '{0, 16'h1234, 0, 0, 16'hFFFF, 16'd0};
    jobs[2] = '{1, 16'h0001, 0, 0, 16'h0001, 16'd1};
    jobs[3] = '{5, 16'h0000, 1, 0, 16'hFFFF, 16'd5};
    jobs[4] = '{4, 16'hF0F0, 1, 1, 16'hF0F0, 16'd4};
    jobs[5] = '{2, 16'h8000, 1, 0, 16'h8000, 16'd2};

    rst_ni = 1'b0; clear_i = 1'b0; start_i = 1'b0; out_beats_i = '0; tail_strb_i = '0;
    inp_valid_i = 1'b0; inp_data_i = '0; wgt_valid_i = 1'b0; wgt_data_i = '0;
    bias_valid_i = 1'b0; bias_data_i = '0; core_inp_ready_i = 1'b0; core_wgt_ready_i = 1'b0;
    core_bias_ready_i = 1'b0; core_oup_valid_i = 1'b0; core_oup_data_i = '0;
    core_busy_i = 1'b0; oup_ready_i = 1'b1;

    repeat (2) @(negedge clk_i);
    chk("rst_oup_valid", oup_valid_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_beat_cnt", beat_cnt_o, 16'd0);
    chk("rst_strb", oup_strb_o, 16'hFFFF);
    chk("rst_inp_ready", inp_ready_o, 1'b0);
    chk("rst_oup_ready", core_oup_ready_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    tick();
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("post_rst_inp_ready", inp_ready_o, 1'b1);
    tick();

    // Input FIFO fills to depth with the core stalled, then drains in order.
    inp_valid_i = 1'b1; core_inp_ready_i = 1'b0; inp_data_i = 128'h1000; acc_n = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      if (i == 0) chk("inp_empty_valid", core_inp_valid_o, 1'b0);
      if (i == 1) begin
        chk("inp_fwft_valid", core_inp_valid_o, 1'b1);
        chk("inp_fwft_data", core_inp_data_o, inp_q[0]);
      end
      if (i == 4) chk("inp_ready_full", inp_ready_o, 1'b0);
      acc = inp_ready_o;
      tick();
      if (acc) begin
        inp_q.push_back(inp_data_i);
        acc_n++;
        inp_data_i = inp_data_i + 128'd1;
      end
    end
    chk("inp_accepted", 32'(acc_n), 32'd4);
    inp_valid_i = 1'b0; core_inp_ready_i = 1'b1; drained = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      if (core_inp_valid_o) begin
        if (inp_q.size() > 0) chk("inp_order", core_inp_data_o, inp_q.pop_front());
        else chk("inp_extra_beat", 1'b1, 1'b0);
        drained++;
      end
      tick();
    end
    chk("inp_drained", 32'(drained), 32'd4);
    core_inp_ready_i = 1'b0;

    // Weight FIFO single-beat pass-through.
    wgt_valid_i = 1'b1; wgt_data_i = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_5555_AAAA; core_wgt_ready_i = 1'b1;
    tick();
    wgt_valid_i = 1'b0;
    @(negedge clk_i);
    chk("wgt_valid", core_wgt_valid_o, 1'b1);
    chk("wgt_data", core_wgt_data_o, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_5555_AAAA);
    tick();
    @(negedge clk_i);
    chk("wgt_popped", core_wgt_valid_o, 1'b0);
    tick();
    core_wgt_ready_i = 1'b0;

    // Bias FIFO with simultaneous push and pop every cycle: never fills, order kept.
    bias_valid_i = 1'b1; core_bias_ready_i = 1'b1; bias_data_i = {12{32'hB0B0_0001}};
    sent = 0; recv = 0; stall_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      if (core_bias_valid_o) begin
        if (bias_q.size() > 0) chk("bias_order", core_bias_data_o, bias_q.pop_front());
        else chk("bias_extra_beat", 1'b1, 1'b0);
        recv++;
      end
      if (bias_valid_i && !bias_ready_o) stall_seen = 1;
      acc = bias_valid_i && bias_ready_o;
      tick();
      if (acc) begin
        bias_q.push_back(bias_data_i);
        sent++;
        bias_data_i = bias_data_i + 384'd1;
        if (sent == 6) bias_valid_i = 1'b0;
      end
    end
    chk("bias_recv", 32'(recv), 32'd6);
    chk("bias_no_stall", stall_seen, 1'b0);
    core_bias_ready_i = 1'b0;

    core_busy_i = 1'b1;
    @(negedge clk_i);
    chk("busy_from_core", busy_o, 1'b1);
    tick();
    core_busy_i = 1'b0;

    for (int k = 0; k < 6; k++) run_job(jobs[k]);

    // Soft clear after 5 of 8 beats, with operand data parked in the input FIFO.
    inp_valid_i = 1'b1; inp_data_i = 128'h77;
    tick();
    tick();
    inp_valid_i = 1'b0;
    start_i = 1'b1; out_beats_i = 16'd8; tail_strb_i = 16'h000F; oup_ready_i = 1'b1;
    core_oup_valid_i = 1'b1; core_oup_data_i = 128'd100;
    tick();
    start_i = 1'b0; got = 0; cyc = 0;
    while (got < 5 && cyc < 100) begin
      @(negedge clk_i);
      acc = core_oup_ready_o;
      if (oup_valid_o && oup_ready_i) got++;
      tick();
      if (acc) core_oup_data_i = core_oup_data_i + 128'd1;
      cyc++;
    end
    chk("clr_pre_cnt", beat_cnt_o, 16'd5);
    clear_i = 1'b1;
    @(negedge clk_i);
    chk("clr_done_suppressed", done_o, 1'b0);
    chk("clr_oup_valid", oup_valid_o, 1'b0);
    chk("clr_inp_ready", inp_ready_o, 1'b0);
    tick();
    clear_i = 1'b0; core_oup_valid_i = 1'b0;
    @(negedge clk_i);
    chk("clr_beat_cnt", beat_cnt_o, 16'd0);
    chk("clr_idle", busy_o, 1'b0);
    chk("clr_inp_empty", core_inp_valid_o, 1'b0);
    chk("clr_oup_empty", core_oup_ready_o, 1'b1);
    any_done = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      @(negedge clk_i);
      if (done_o) any_done = 1;
    end
    chk("clr_no_done", any_done, 1'b0);
    tick();

    // Reset for two cycles in the middle of a 4-beat job.
    start_i = 1'b1; out_beats_i = 16'd4; tail_strb_i = 16'h0003; oup_ready_i = 1'b1;
    core_oup_valid_i = 1'b1; core_oup_data_i = 128'd500;
    tick();
    start_i = 1'b0; got = 0; cyc = 0;
    while (got < 2 && cyc < 100) begin
      @(negedge clk_i);
      if (oup_valid_o && oup_ready_i) got++;
      tick();
      cyc++;
    end
    rst_ni = 1'b0;
    @(negedge clk_i);
    chk("mid_rst_oup_valid", oup_valid_o, 1'b0);
    chk("mid_rst_beat_cnt", beat_cnt_o, 16'd0);
    chk("mid_rst_strb", oup_strb_o, 16'hFFFF);
    chk("mid_rst_ready", {inp_ready_o, wgt_ready_o, bias_ready_o, core_oup_ready_o}, 4'b0000);
    chk("mid_rst_busy", busy_o, 1'b0);
    tick();
    tick();
    rst_ni = 1'b1; core_oup_valid_i = 1'b0;
    any_done = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      if (done_o || oup_valid_o) any_done = 1;
      tick();
    end
    chk("post_rst_no_done", any_done, 1'b0);
    chk("post_rst_beat_cnt", beat_cnt_o, 16'd0);

    exp_q.delete();
    run_job(jobs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
